// File: rtl/nios_system_sysid_boot_checker_if.sv
// rtl/nios_system_sysid_boot_checker_if.sv - Avalon-MM read port between boot checker and sysid slave
interface nios_system_sysid_boot_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/nios_system_sysid_boot_checker.sv
// rtl/nios_system_sysid_boot_checker.sv - boot-time sysid read/compare sequencer gating core_enable
module nios_system_sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd1,
    parameter logic [31:0] EXPECTED_TS    = 32'd1410722852,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3,
    parameter int          RETRY_GAP      = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    nios_system_sysid_boot_checker_if.master  avm,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              core_enable,
    output logic [1:0]                        fail_code,
    output logic [3:0]                        retry_count,
    output logic [31:0]                       id_value,
    output logic [31:0]                       ts_value
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RD_ID      = 3'd1;
    localparam logic [2:0] S_RD_TS      = 3'd2;
    localparam logic [2:0] S_CHECK      = 3'd3;
    localparam logic [2:0] S_RETRY_WAIT = 3'd4;
    localparam logic [2:0] S_DONE_OK    = 3'd5;
    localparam logic [2:0] S_DONE_FAIL  = 3'd6;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_TIMEOUT  = 2'd1;
    localparam logic [1:0] FC_ID_MISM  = 2'd2;
    localparam logic [1:0] FC_TS_MISM  = 2'd3;

    // The stall that would be number TIMEOUT_CYCLES is the one that aborts the read.
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);
    localparam logic [7:0] GAP_LOAD    = 8'(RETRY_GAP - 1);

    logic [2:0] state;
    logic [7:0] stall_cnt;
    logic [7:0] gap_cnt;
    logic       fail_now;
    logic [1:0] fail_cause;

    always_comb begin
        fail_now   = 1'b0;
        fail_cause = FC_NONE;
        case (state)
            S_RD_ID, S_RD_TS: begin
                if (avm.avm_waitrequest && (stall_cnt == STALL_LIMIT)) begin
                    fail_now   = 1'b1;
                    fail_cause = FC_TIMEOUT;
                end
            end
            S_CHECK: begin
                if (id_value != EXPECTED_ID) begin
                    fail_now   = 1'b1;
                    fail_cause = FC_ID_MISM;
                end else if (CHECK_TS && (ts_value != EXPECTED_TS)) begin
                    fail_now   = 1'b1;
                    fail_cause = FC_TS_MISM;
                end
            end
            default: begin
                fail_now   = 1'b0;
                fail_cause = FC_NONE;
            end
        endcase
    end

    assign avm.avm_read    = (state == S_RD_ID) || (state == S_RD_TS);
    assign avm.avm_address = (state == S_RD_TS);
    assign busy            = !((state == S_IDLE) || (state == S_DONE_OK) || (state == S_DONE_FAIL));
    assign core_enable     = pass;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            stall_cnt   <= 8'd0;
            gap_cnt     <= 8'd0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
            retry_count <= 4'd0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE_OK, S_DONE_FAIL: begin
                    if (start) begin
                        state       <= S_RD_ID;
                        stall_cnt   <= 8'd0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail_code   <= FC_NONE;
                        retry_count <= 4'd0;
                    end
                end
                S_RD_ID: begin
                    if (!avm.avm_waitrequest) begin
                        id_value  <= avm.avm_readdata;
                        stall_cnt <= 8'd0;
                        state     <= S_RD_TS;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                S_RD_TS: begin
                    if (!avm.avm_waitrequest) begin
                        ts_value  <= avm.avm_readdata;
                        stall_cnt <= 8'd0;
                        state     <= S_CHECK;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (!fail_now) begin
                        state     <= S_DONE_OK;
                        done      <= 1'b1;
                        pass      <= 1'b1;
                        fail_code <= FC_NONE;
                    end
                end
                S_RETRY_WAIT: begin
                    if (gap_cnt == 8'd0) begin
                        state       <= S_RD_ID;
                        stall_cnt   <= 8'd0;
                        retry_count <= retry_count + 4'd1;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Timeouts and compare failures share one exit path; it overrides the per-state updates.
            if (fail_now) begin
                fail_code <= fail_cause;
                if (retry_count < RETRY_LIMIT) begin
                    state   <= S_RETRY_WAIT;
                    gap_cnt <= GAP_LOAD;
                end else begin
                    state <= S_DONE_FAIL;
                    done  <= 1'b1;
                    pass  <= 1'b0;
                end
            end
        end
    end

endmodule
